// File: rtl/ex_ctrl_stage.sv
// EX control provider stage: decodes the RV32I instruction from ID and registers the EX control bundle.
// Optional macro EX_CTRL_ILLEGAL_DETECT_EN enables the registered illegal-instruction flag.
module ex_ctrl_stage #(
    parameter logic [3:0] ALU_NOP = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [3:0]  ALUControl,
    output logic        ALUSrcB,
    output logic        PCOffset,
    output logic        illegal
);

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OPIMM  = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_e;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    function automatic alu_op_e funct3_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign funct7            = instr[31:25];
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    logic [3:0] dec_alu;
    logic       dec_srcb;
    logic       dec_pcoff;
    logic       dec_bad;

    always_comb begin
        dec_alu   = ALU_ADD;
        dec_srcb  = 1'b0;
        dec_pcoff = 1'b0;
        dec_bad   = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_alu = funct3_op(funct3, funct7[5]);
                dec_bad = !((funct7 == F7_BASE) ||
                            ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OPC_OPIMM: begin
                dec_srcb = 1'b1;
                dec_alu  = funct3_op(funct3, (funct3 == 3'b101) && funct7[5]);
                dec_bad  = ((funct3 == 3'b001) && (funct7 != F7_BASE)) ||
                           ((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT));
            end
            OPC_LOAD, OPC_STORE, OPC_AUIPC, OPC_JAL: begin
                dec_srcb = 1'b1;
            end
            OPC_JALR: begin
                dec_srcb  = 1'b1;
                dec_pcoff = 1'b1;
                dec_bad   = (funct3 != 3'b000);
            end
            OPC_LUI: begin
                dec_alu  = ALU_PASS_B;
                dec_srcb = 1'b1;
            end
            OPC_BRANCH: begin
                case (funct3[2:1])
                    2'b00:   dec_alu = ALU_SUB;
                    2'b10:   dec_alu = ALU_SLT;
                    2'b11:   dec_alu = ALU_SLTU;
                    default: dec_bad = 1'b1;
                endcase
            end
            default: dec_bad = 1'b1;
        endcase
        // Unsupported encodings collapse to a harmless bundle; only the ALU value differs by build.
        if (dec_bad) begin
`ifdef EX_CTRL_ILLEGAL_DETECT_EN
            dec_alu = ALU_NOP;
`else
            dec_alu = ALU_ADD;
`endif
            dec_srcb  = 1'b0;
            dec_pcoff = 1'b0;
        end
    end

    logic       ex_valid_q, ex_valid_d;
    logic [3:0] alu_q, alu_d;
    logic       srcb_q, srcb_d;
    logic       pcoff_q, pcoff_d;
    logic       capture;

    assign id_ready = ex_ready || !ex_valid_q;
    assign capture  = id_valid && id_ready && !flush;

`ifdef EX_CTRL_ILLEGAL_DETECT_EN
    logic illegal_q, illegal_d;
`endif

    always_comb begin
        ex_valid_d = ex_valid_q;
        alu_d      = alu_q;
        srcb_d     = srcb_q;
        pcoff_d    = pcoff_q;
`ifdef EX_CTRL_ILLEGAL_DETECT_EN
        illegal_d  = illegal_q;
`endif
        if (flush || (!capture && ex_ready)) begin
            ex_valid_d = 1'b0;
            alu_d      = ALU_NOP;
            srcb_d     = 1'b0;
            pcoff_d    = 1'b0;
`ifdef EX_CTRL_ILLEGAL_DETECT_EN
            illegal_d  = 1'b0;
`endif
        end else if (capture) begin
            ex_valid_d = 1'b1;
            alu_d      = dec_alu;
            srcb_d     = dec_srcb;
            pcoff_d    = dec_pcoff;
`ifdef EX_CTRL_ILLEGAL_DETECT_EN
            illegal_d  = dec_bad;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            alu_q      <= ALU_NOP;
            srcb_q     <= 1'b0;
            pcoff_q    <= 1'b0;
`ifdef EX_CTRL_ILLEGAL_DETECT_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            ex_valid_q <= ex_valid_d;
            alu_q      <= alu_d;
            srcb_q     <= srcb_d;
            pcoff_q    <= pcoff_d;
`ifdef EX_CTRL_ILLEGAL_DETECT_EN
            illegal_q  <= illegal_d;
`endif
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ALUControl = alu_q;
    assign ALUSrcB    = srcb_q;
    assign PCOffset   = pcoff_q;
`ifdef EX_CTRL_ILLEGAL_DETECT_EN
    assign illegal    = illegal_q;
`else
    assign illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_ex_ctrl_stage.sv
// Self-checking bench for ex_ctrl_stage: directed scenarios plus randomized traffic against
// a mask/match instruction-table reference model.
module tb_ex_ctrl_stage;

    localparam logic [3:0] NOP = 4'hF;
`ifdef EX_CTRL_ILLEGAL_DETECT_EN
    localparam bit DET = 1'b1;
`else
    localparam bit DET = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        id_valid = 1'b0;
    logic        id_ready;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b0;
    logic        ex_valid;
    logic [3:0]  ALUControl;
    logic        ALUSrcB;
    logic        PCOffset;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_ctrl_stage #(.ALU_NOP(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .flush      (flush),
        .ex_ready   (ex_ready),
        .ex_valid   (ex_valid),
        .ALUControl (ALUControl),
        .ALUSrcB    (ALUSrcB),
        .PCOffset   (PCOffset),
        .illegal    (illegal)
    );

    // Reference: table of legal RV32I encodings (mask/match) with their EX control bundle.
    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        logic [3:0]  alu;
        logic        srcb;
        logic        pcoff;
    } pat_t;
    pat_t pats[$];

    task automatic add_pat(input logic [31:0] m, input logic [31:0] v, input logic [3:0] a,
                           input logic s, input logic p);
        pat_t t;
        t.mask = m; t.match = v; t.alu = a; t.srcb = s; t.pcoff = p;
        pats.push_back(t);
    endtask

    task automatic build_table();
        add_pat(32'hFE00707F, 32'h00000033, 4'd0, 0, 0);   // add
        add_pat(32'hFE00707F, 32'h40000033, 4'd1, 0, 0);   // sub
        add_pat(32'hFE00707F, 32'h00001033, 4'd2, 0, 0);   // sll
        add_pat(32'hFE00707F, 32'h00002033, 4'd3, 0, 0);   // slt
        add_pat(32'hFE00707F, 32'h00003033, 4'd4, 0, 0);   // sltu
        add_pat(32'hFE00707F, 32'h00004033, 4'd5, 0, 0);   // xor
        add_pat(32'hFE00707F, 32'h00005033, 4'd6, 0, 0);   // srl
        add_pat(32'hFE00707F, 32'h40005033, 4'd7, 0, 0);   // sra
        add_pat(32'hFE00707F, 32'h00006033, 4'd8, 0, 0);   // or
        add_pat(32'hFE00707F, 32'h00007033, 4'd9, 0, 0);   // and
        add_pat(32'h0000707F, 32'h00000013, 4'd0, 1, 0);   // addi
        add_pat(32'h0000707F, 32'h00002013, 4'd3, 1, 0);   // slti
        add_pat(32'h0000707F, 32'h00003013, 4'd4, 1, 0);   // sltiu
        add_pat(32'h0000707F, 32'h00004013, 4'd5, 1, 0);   // xori
        add_pat(32'h0000707F, 32'h00006013, 4'd8, 1, 0);   // ori
        add_pat(32'h0000707F, 32'h00007013, 4'd9, 1, 0);   // andi
        add_pat(32'hFE00707F, 32'h00001013, 4'd2, 1, 0);   // slli
        add_pat(32'hFE00707F, 32'h00005013, 4'd6, 1, 0);   // srli
        add_pat(32'hFE00707F, 32'h40005013, 4'd7, 1, 0);   // srai
        add_pat(32'h0000007F, 32'h00000003, 4'd0, 1, 0);   // loads
        add_pat(32'h0000007F, 32'h00000023, 4'd0, 1, 0);   // stores
        add_pat(32'h0000007F, 32'h00000017, 4'd0, 1, 0);   // auipc
        add_pat(32'h0000007F, 32'h0000006F, 4'd0, 1, 0);   // jal
        add_pat(32'h0000707F, 32'h00000067, 4'd0, 1, 1);   // jalr
        add_pat(32'h0000007F, 32'h00000037, 4'd10, 1, 0);  // lui
        add_pat(32'h0000707F, 32'h00000063, 4'd1, 0, 0);   // beq
        add_pat(32'h0000707F, 32'h00001063, 4'd1, 0, 0);   // bne
        add_pat(32'h0000707F, 32'h00004063, 4'd3, 0, 0);   // blt
        add_pat(32'h0000707F, 32'h00005063, 4'd3, 0, 0);   // bge
        add_pat(32'h0000707F, 32'h00006063, 4'd4, 0, 0);   // bltu
        add_pat(32'h0000707F, 32'h00007063, 4'd4, 0, 0);   // bgeu
    endtask

    // Model of what EX currently holds.
    logic       m_valid = 1'b0;
    logic [3:0] m_alu   = NOP;
    logic       m_srcb  = 1'b0;
    logic       m_pc    = 1'b0;
    logic       m_ill   = 1'b0;

    task automatic model_empty();
        m_valid = 1'b0; m_alu = NOP; m_srcb = 1'b0; m_pc = 1'b0; m_ill = 1'b0;
    endtask

    task automatic model_load(input logic [31:0] w);
        bit found = 1'b0;
        m_valid = 1'b1;
        foreach (pats[k]) begin
            if (!found && ((w & pats[k].mask) == pats[k].match)) begin
                found = 1'b1;
                m_alu = pats[k].alu; m_srcb = pats[k].srcb; m_pc = pats[k].pcoff; m_ill = 1'b0;
            end
        end
        if (!found) begin
            m_alu = DET ? NOP : 4'd0; m_srcb = 1'b0; m_pc = 1'b0; m_ill = DET;
        end
    endtask

    // Advance one clock with the currently driven inputs and step the model.
    task automatic tick();
        bit accepted;
        accepted = id_valid && (ex_ready || !m_valid);
        @(posedge clk);
        if (rst || flush)   model_empty();
        else if (accepted)  model_load(instr);
        else if (ex_ready)  model_empty();
        #1;
    endtask

    task automatic drive(input logic r, input logic [31:0] w, input logic v,
                         input logic f, input logic e);
        rst = r; instr = w; id_valid = v; flush = f; ex_ready = e;
        #1;
    endtask

    task automatic test_reset();
        drive(1, 32'h002081B3, 1, 0, 1);
        tick();
        tick();
        drive(0, 32'h0, 0, 0, 0);
        n_checks++;
        if (ex_valid !== 1'b0 || ALUControl !== NOP || ALUSrcB !== 1'b0 || PCOffset !== 1'b0 || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%0b alu=%0h b=%0b pc=%0b ill=%0b, want 0 %0h 0 0 0",
                     ex_valid, ALUControl, ALUSrcB, PCOffset, illegal, NOP);
        end
        n_checks++;
        if (id_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_id_ready: got %0b want 1", id_ready);
        end
    endtask

    task automatic test_decode_examples();
        drive(0, 32'h002081B3, 1, 0, 1); tick();
        n_checks++;
        if (ex_valid !== 1'b1 || ALUControl !== 4'd0 || ALUSrcB !== 1'b0 || PCOffset !== 1'b0) begin
            n_fail++; $display("FAIL add_decode: got v=%0b alu=%0d b=%0b pc=%0b, want 1 0 0 0",
                               ex_valid, ALUControl, ALUSrcB, PCOffset);
        end
        drive(0, 32'h402081B3, 1, 0, 1); tick();
        n_checks++;
        if (ex_valid !== 1'b1 || ALUControl !== 4'd1) begin
            n_fail++; $display("FAIL sub_decode: got v=%0b alu=%0d, want 1 1", ex_valid, ALUControl);
        end
        drive(0, 32'h000080E7, 1, 0, 1); tick();
        n_checks++;
        if (ALUControl !== 4'd0 || ALUSrcB !== 1'b1 || PCOffset !== 1'b1) begin
            n_fail++; $display("FAIL jalr_decode: got alu=%0d b=%0b pc=%0b, want 0 1 1",
                               ALUControl, ALUSrcB, PCOffset);
        end
        drive(0, 32'h4030D093, 1, 0, 1); tick();
        n_checks++;
        if (ALUControl !== 4'd7 || ALUSrcB !== 1'b1 || PCOffset !== 1'b0) begin
            n_fail++; $display("FAIL srai_decode: got alu=%0d b=%0b pc=%0b, want 7 1 0",
                               ALUControl, ALUSrcB, PCOffset);
        end
        drive(0, 32'h000000B7, 0, 0, 1); tick();
        n_checks++;
        if (ex_valid !== 1'b0 || ALUControl !== NOP || ALUSrcB !== 1'b0) begin
            n_fail++; $display("FAIL drain: got v=%0b alu=%0h b=%0b, want 0 %0h 0",
                               ex_valid, ALUControl, ALUSrcB, NOP);
        end
    endtask

    task automatic test_hold();
        drive(0, 32'h002081B3, 1, 0, 1); tick();
        for (int unsigned c = 0; c < 3; c++) begin
            drive(0, 32'h402081B3, 1, 0, 0);
            n_checks++;
            if (id_ready !== 1'b0) begin
                n_fail++; $display("FAIL hold_id_ready: cycle %0d got %0b want 0", c, id_ready);
            end
            tick();
            n_checks++;
            if (ex_valid !== 1'b1 || ALUControl !== 4'd0) begin
                n_fail++; $display("FAIL hold_outputs: cycle %0d got v=%0b alu=%0d want 1 0",
                                   c, ex_valid, ALUControl);
            end
        end
        drive(0, 32'h402081B3, 1, 0, 1);
        n_checks++;
        if (id_ready !== 1'b1) begin
            n_fail++; $display("FAIL release_id_ready: got %0b want 1", id_ready);
        end
        tick();
        n_checks++;
        if (ex_valid !== 1'b1 || ALUControl !== 4'd1) begin
            n_fail++; $display("FAIL release_capture: got v=%0b alu=%0d want 1 1", ex_valid, ALUControl);
        end
    endtask

    task automatic test_flush();
        drive(0, 32'h000080E7, 1, 1, 1); tick();
        n_checks++;
        if (ex_valid !== 1'b0 || ALUControl !== NOP || PCOffset !== 1'b0) begin
            n_fail++; $display("FAIL flush_capture: got v=%0b alu=%0h pc=%0b want 0 %0h 0",
                               ex_valid, ALUControl, PCOffset, NOP);
        end
        drive(0, 32'h000080E7, 1, 0, 1); tick();
        drive(0, 32'h002081B3, 1, 1, 0); tick();
        n_checks++;
        if (ex_valid !== 1'b0 || ALUControl !== NOP || PCOffset !== 1'b0 || ALUSrcB !== 1'b0) begin
            n_fail++; $display("FAIL flush_hold: got v=%0b alu=%0h pc=%0b b=%0b want 0 %0h 0 0",
                               ex_valid, ALUControl, PCOffset, ALUSrcB, NOP);
        end
    endtask

    task automatic test_reset_mid_hold();
        drive(0, 32'h4030D093, 1, 0, 1); tick();
        drive(0, 32'h002081B3, 1, 0, 0); tick();
        drive(1, 32'h002081B3, 1, 0, 0); tick();
        drive(0, 32'h002081B3, 0, 0, 0);
        n_checks++;
        if (ex_valid !== 1'b0 || ALUControl !== NOP || ALUSrcB !== 1'b0 || PCOffset !== 1'b0 ||
            illegal !== 1'b0 || id_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_hold: got v=%0b alu=%0h b=%0b pc=%0b ill=%0b rdy=%0b want 0 %0h 0 0 0 1",
                               ex_valid, ALUControl, ALUSrcB, PCOffset, illegal, id_ready, NOP);
        end
    endtask

    task automatic test_illegal();
        logic [3:0] want_alu;
        want_alu = DET ? NOP : 4'd0;
        drive(0, 32'hFFFFFFFF, 1, 0, 1); tick();
        n_checks++;
        if (ex_valid !== 1'b1 || illegal !== DET || ALUControl !== want_alu || ALUSrcB !== 1'b0) begin
            n_fail++; $display("FAIL illegal_all_ones: got v=%0b ill=%0b alu=%0h b=%0b want 1 %0b %0h 0",
                               ex_valid, illegal, ALUControl, ALUSrcB, DET, want_alu);
        end
        drive(0, 32'h0000A0E7, 1, 0, 1); tick();   // jalr with funct3=010
        n_checks++;
        if (illegal !== DET || PCOffset !== 1'b0 || ALUSrcB !== 1'b0) begin
            n_fail++; $display("FAIL illegal_jalr_f3: got ill=%0b pc=%0b b=%0b want %0b 0 0",
                               illegal, PCOffset, ALUSrcB, DET);
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [6:0]  opcs [9];
        opcs = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};
        for (int unsigned n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    w = $urandom;
                2, 3:    begin w = $urandom; w[6:0] = opcs[$urandom_range(0, 8)]; end
                default: begin
                    int unsigned k;
                    k = $urandom_range(0, pats.size() - 1);
                    w = ($urandom & ~pats[k].mask) | pats[k].match;
                end
            endcase
            drive($urandom_range(0, 49) == 0, w, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0));
            n_checks++;
            if (id_ready !== (ex_ready || !m_valid)) begin
                n_fail++; $display("FAIL rnd_id_ready: iter %0d got %0b want %0b", n, id_ready, ex_ready || !m_valid);
            end
            tick();
            n_checks++;
            if (ex_valid !== m_valid || ALUControl !== m_alu || ALUSrcB !== m_srcb ||
                PCOffset !== m_pc || illegal !== m_ill) begin
                n_fail++;
                $display("FAIL rnd_bundle: iter %0d instr=%08h got v=%0b alu=%0h b=%0b pc=%0b ill=%0b want %0b %0h %0b %0b %0b",
                         n, instr, ex_valid, ALUControl, ALUSrcB, PCOffset, illegal,
                         m_valid, m_alu, m_srcb, m_pc, m_ill);
            end
        end
    endtask

    initial begin
        build_table();
        test_reset();
        test_decode_examples();
        test_hold();
        test_flush();
        test_reset_mid_hold();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
